// File: rtl/frequency_measurement_scheduler_pkg.sv
// Shared types and defaults for the frequency-analyzer measurement scheduler.
// Holds the state encoding and the default timing constants.
package frequency_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_STOP_WAIT = 3'd3,
    ST_RELEASE   = 3'd4
  } sched_state_t;

  localparam int DEF_WINDOW_WIDTH       = 32;
  localparam int DEF_START_PULSE_CYCLES = 4;
  localparam int DEF_CLEAR_CYCLES       = 4;
  localparam int DEF_IRQ_TIMEOUT_CYCLES = 1024;
  localparam int DEF_COUNT_WIDTH        = 16;

  // Width of a down-counter able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/frequency_measurement_scheduler_if.sv
// Control link between the scheduler and the frequency-analyzer manager.
interface frequency_measurement_scheduler_if;
  // start, stop and clear are registered levels from the scheduler; irq is a
  // level from the manager, held high from results-written until stop drops.
  // There is no valid/ready pair: each side samples the other's levels on clock.
  logic start;
  logic stop;
  logic clear;
  logic irq;

  modport master (output start, output stop, output clear, input irq);
  modport slave  (input start, input stop, input clear, output irq);
endinterface

// File: rtl/frequency_measurement_scheduler_pulse_stretch_counter.sv
// Loadable down-counter; term is high while the count is at its last cycle.
module pulse_stretch_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         term
);
  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign term = (count <= W'(1));
endmodule

// File: rtl/frequency_measurement_scheduler.sv
// Sequences start / measurement window / stop / clear cycles for the
// frequency-analyzer manager and supervises the irq wait with a timeout.
module frequency_measurement_scheduler
  import frequency_scheduler_pkg::*;
#(
  parameter int WINDOW_WIDTH       = DEF_WINDOW_WIDTH,
  parameter int START_PULSE_CYCLES = DEF_START_PULSE_CYCLES,
  parameter int CLEAR_CYCLES       = DEF_CLEAR_CYCLES,
  parameter int IRQ_TIMEOUT_CYCLES = DEF_IRQ_TIMEOUT_CYCLES,
  parameter int COUNT_WIDTH        = DEF_COUNT_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    continuous,
  input  logic [WINDOW_WIDTH-1:0] window_cycles,
  frequency_measurement_scheduler_if.master mgr,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [COUNT_WIDTH-1:0]  measure_count,
  output sched_state_t            state_dbg
);
  localparam int SW = cnt_width(START_PULSE_CYCLES);
  localparam int CW = cnt_width(CLEAR_CYCLES);
  localparam int TW = cnt_width(IRQ_TIMEOUT_CYCLES);

  sched_state_t          state, state_next;
  logic                  run_q;
  logic                  run_rise;
  logic [WINDOW_WIDTH-1:0] win_len;
  logic [TW-1:0]         to_cnt;
  logic                  to_hit;
  logic                  start_term, win_term, clr_term;

  assign run_rise  = run & ~run_q;
  assign to_hit    = (to_cnt == TW'(IRQ_TIMEOUT_CYCLES - 1));
  assign state_dbg = state;

  pulse_stretch_counter #(.W(SW)) u_start_cnt (
    .clock(clock), .reset(reset),
    .load(state != ST_ARM), .en(state == ST_ARM),
    .load_value(SW'(START_PULSE_CYCLES)), .term(start_term)
  );

  pulse_stretch_counter #(.W(WINDOW_WIDTH)) u_window_cnt (
    .clock(clock), .reset(reset),
    .load(state != ST_MEASURE), .en(state == ST_MEASURE),
    .load_value(win_len), .term(win_term)
  );

  pulse_stretch_counter #(.W(CW)) u_clear_cnt (
    .clock(clock), .reset(reset),
    .load(state != ST_RELEASE), .en(state == ST_RELEASE),
    .load_value(CW'(CLEAR_CYCLES)), .term(clr_term)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Dropping run in ARM or MEASURE still reads out the partial window.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if ((continuous && run) || (!continuous && run_rise)) state_next = ST_ARM;
      end
      ST_ARM: begin
        if (!run)            state_next = ST_STOP_WAIT;
        else if (start_term) state_next = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (!run || win_term) state_next = ST_STOP_WAIT;
      end
      ST_STOP_WAIT: begin
        if (mgr.irq || to_hit) state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (clr_term) state_next = (run && continuous) ? ST_ARM : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      run_q   <= 1'b0;
      win_len <= '0;
      to_cnt  <= '0;
    end else begin
      run_q <= run;
      if ((state == ST_IDLE || state == ST_RELEASE) && state_next == ST_ARM)
        win_len <= (window_cycles == '0) ? WINDOW_WIDTH'(1) : window_cycles;
      if (state == ST_STOP_WAIT) to_cnt <= to_cnt + 1'b1;
      else                       to_cnt <= '0;
    end
  end

  // Outputs are decoded from the next state so they track the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      mgr.start     <= 1'b0;
      mgr.stop      <= 1'b0;
      mgr.clear     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      measure_count <= '0;
    end else begin
      mgr.start <= (state_next == ST_ARM);
      mgr.stop  <= (state_next == ST_STOP_WAIT);
      mgr.clear <= (state_next == ST_RELEASE);
      busy      <= (state_next != ST_IDLE);
      done      <= (state == ST_STOP_WAIT) && mgr.irq;
      if (state == ST_STOP_WAIT && mgr.irq)
        measure_count <= measure_count + 1'b1;
      if (state == ST_STOP_WAIT && !mgr.irq && to_hit)
        timeout_err <= 1'b1;
      else if (state == ST_IDLE && run_rise)
        timeout_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_frequency_measurement_scheduler.sv
// Bench for frequency_measurement_scheduler: a manager model answers stop with
// irq after a chosen delay; each finished cycle is compared to a queued record.
module tb_frequency_measurement_scheduler;
  import frequency_scheduler_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         run;
  logic         continuous;
  logic [31:0]  window_cycles;
  logic         busy, done, timeout_err;
  logic [15:0]  measure_count;
  sched_state_t state_dbg;

  frequency_measurement_scheduler_if mgr();

  frequency_measurement_scheduler dut (
    .clock(clock), .reset(reset), .run(run), .continuous(continuous),
    .window_cycles(window_cycles), .mgr(mgr), .busy(busy), .done(done),
    .timeout_err(timeout_err), .measure_count(measure_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  int exp_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // scoreboard: one record per cycle {start, window, stop, clear, done} lengths
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  function automatic logic [63:0] rec(input int st, input int win, input int sp,
                                      input int cl, input int dn);
    return {12'(st), 16'(win), 12'(sp), 12'(cl), 12'(dn)};
  endfunction

  int   st_n, win_n, sp_n, cl_n, dn_n;
  logic prev_clear;

  always @(negedge clock) begin
    if (reset) begin
      st_n = 0; win_n = 0; sp_n = 0; cl_n = 0; dn_n = 0;
      prev_clear = 1'b0;
    end else begin
      if (prev_clear && !mgr.clear) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_record", 64'(1), 64'(0));
        end else begin
          mon_exp = exp_q.pop_front();
          check("rec_start_len",  64'(st_n),  64'(mon_exp[63:52]));
          check("rec_window_len", 64'(win_n), 64'(mon_exp[51:36]));
          check("rec_stop_len",   64'(sp_n),  64'(mon_exp[35:24]));
          check("rec_clear_len",  64'(cl_n),  64'(mon_exp[23:12]));
          check("rec_done_pulses",64'(dn_n),  64'(mon_exp[11:0]));
        end
        st_n = 0; win_n = 0; sp_n = 0; cl_n = 0; dn_n = 0;
      end
      if (mgr.start)                  st_n++;
      else if (mgr.stop)              sp_n++;
      else if (mgr.clear)             cl_n++;
      else if (busy && st_n > 0)      win_n++;
      if (done) dn_n++;
      prev_clear = mgr.clear;
    end
  end

  // manager model: irq rises irq_delay cycles into stop, drops when stop drops
  int irq_delay = -1;
  int sp_cnt;
  initial begin
    mgr.irq = 1'b0;
    sp_cnt  = 0;
    forever begin
      @(negedge clock);
      if (mgr.stop) begin
        if (irq_delay >= 0 && sp_cnt == irq_delay) mgr.irq = 1'b1;
        sp_cnt++;
      end else begin
        mgr.irq = 1'b0;
        sp_cnt  = 0;
      end
    end
  end

  // driver tasks
  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (busy !== lvl) check(tag, 64'(busy), 64'(lvl));
  endtask

  task automatic wait_start(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (mgr.start !== lvl && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (mgr.start !== lvl) check(tag, 64'(mgr.start), 64'(lvl));
  endtask

  task automatic run_single(input int win, input int dly, input int exp_win,
                            input int exp_sp, input int exp_dn);
    @(negedge clock);
    continuous    = 1'b0;
    window_cycles = 32'(win);
    irq_delay     = dly;
    run           = 1'b0;
    exp_q.push_back(rec(4, exp_win, exp_sp, 4, exp_dn));
    exp_count += exp_dn;
    @(negedge clock);
    run = 1'b1;
    wait_busy(1'b1, 10, "arm_wait_timeout");
    wait_busy(1'b0, 3000, "idle_wait_timeout");
    run = 1'b0;
  endtask

  initial begin
    int dn_seen, busy_low, n;
    reset = 1'b1; run = 1'b0; continuous = 1'b0; window_cycles = 32'd100;
    repeat (3) @(negedge clock);
    check("rst_start", 64'(mgr.start), 64'(0));
    check("rst_stop", 64'(mgr.stop), 64'(0));
    check("rst_clear", 64'(mgr.clear), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_timeout_err", 64'(timeout_err), 64'(0));
    check("rst_count", 64'(measure_count), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    reset = 1'b0;

    // single shot, irq 20 cycles into stop
    run_single(100, 20, 100, 21, 1);
    check("t1_count", 64'(measure_count), 64'(exp_count));
    check("t1_state", 64'(state_dbg), 64'(ST_IDLE));

    // continuous back-to-back cycles
    @(negedge clock);
    continuous = 1'b1; window_cycles = 32'd10; irq_delay = 3;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(rec(4, 10, 4, 4, 1));
      exp_count++;
    end
    run = 1'b1;
    dn_seen = 0; busy_low = 0; n = 0;
    while (dn_seen < 5 && n < 2000) begin
      @(negedge clock);
      n++;
      if (done) dn_seen++;
      if (!busy) busy_low++;
    end
    run = 1'b0;
    check("t2_done_seen", 64'(dn_seen), 64'(5));
    check("t2_busy_gaps", 64'(busy_low), 64'(0));
    wait_busy(1'b0, 100, "t2_idle_timeout");
    check("t2_count", 64'(measure_count), 64'(exp_count));
    check("t2_state", 64'(state_dbg), 64'(ST_IDLE));
    continuous = 1'b0;

    // irq never comes: full timeout
    run_single(10, -1, 10, 1024, 0);
    check("t3_timeout_err", 64'(timeout_err), 64'(1));
    check("t3_count", 64'(measure_count), 64'(exp_count));
    @(negedge clock);
    irq_delay = 5;
    exp_q.push_back(rec(4, 10, 6, 4, 1));
    exp_count++;
    run = 1'b1;
    @(negedge clock);
    check("t3_err_cleared", 64'(timeout_err), 64'(0));
    check("t3_rearm_busy", 64'(busy), 64'(1));
    wait_busy(1'b0, 200, "t3_idle_timeout");
    run = 1'b0;

    // irq on the last timeout cycle wins
    run_single(10, 1023, 10, 1024, 1);
    check("t4_timeout_err", 64'(timeout_err), 64'(0));
    check("t4_count", 64'(measure_count), 64'(exp_count));

    // run dropped at measure cycle 5 of 100
    @(negedge clock);
    window_cycles = 32'd100; irq_delay = 2;
    exp_q.push_back(rec(4, 5, 3, 4, 1));
    exp_count++;
    run = 1'b1;
    wait_start(1'b1, 10, "t5_start_timeout");
    wait_start(1'b0, 10, "t5_measure_timeout");
    repeat (4) @(negedge clock);
    run = 1'b0;
    @(negedge clock);
    check("t5_state", 64'(state_dbg), 64'(ST_STOP_WAIT));
    check("t5_stop", 64'(mgr.stop), 64'(1));
    wait_busy(1'b0, 100, "t5_idle_timeout");
    check("t5_count", 64'(measure_count), 64'(exp_count));

    // zero window becomes one cycle
    run_single(0, 1, 1, 2, 1);

    // window_cycles changed mid-measure is ignored
    @(negedge clock);
    window_cycles = 32'd100; irq_delay = 4;
    exp_q.push_back(rec(4, 100, 5, 4, 1));
    exp_count++;
    run = 1'b1;
    wait_start(1'b1, 10, "t6_start_timeout");
    wait_start(1'b0, 10, "t6_measure_timeout");
    window_cycles = 32'd5;
    wait_busy(1'b0, 300, "t6_idle_timeout");
    run = 1'b0;
    check("t6_count", 64'(measure_count), 64'(exp_count));

    // reset during stop_wait
    @(negedge clock);
    window_cycles = 32'd10; irq_delay = -1;
    run = 1'b1;
    n = 0;
    while (state_dbg != ST_STOP_WAIT && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("t7_reached_stop_wait", 64'(state_dbg), 64'(ST_STOP_WAIT));
    repeat (3) @(negedge clock);
    reset = 1'b1; run = 1'b0;
    @(negedge clock);
    check("t7_start", 64'(mgr.start), 64'(0));
    check("t7_stop", 64'(mgr.stop), 64'(0));
    check("t7_clear", 64'(mgr.clear), 64'(0));
    check("t7_busy", 64'(busy), 64'(0));
    check("t7_state", 64'(state_dbg), 64'(ST_IDLE));
    check("t7_count", 64'(measure_count), 64'(0));
    exp_count = 0;
    reset = 1'b0;

    run_single(10, 0, 10, 1, 1);
    check("t8_count", 64'(measure_count), 64'(exp_count));

    repeat (3) @(negedge clock);
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
